// File: rtl/col_drain_pkg.sv
// Shared types and width helpers for the column drain scheduler.
package col_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Counter width that stays at least one bit even for a single entry.
  function automatic int max1_clog2(input int n);
    int w;
    w = $clog2(n);
    max1_clog2 = (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/drain_data_mux.sv
// Registers each issued read and steers the returning column word to the final FIFO.
module drain_data_mux
  import col_drain_pkg::*;
#(
  parameter int COL = 3,
  parameter int DW  = 9,
  localparam int COL_W = max1_clog2(COL)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_issue,
  input  logic [COL_W-1:0]  i_col,
  input  logic [DW*COL-1:0] i_data,
  output logic [DW-1:0]     o_data,
  output logic              o_wren
);

  logic             rd_vld_d, rd_vld_q;
  logic [COL_W-1:0] rd_col_d, rd_col_q;

  // Next values of the in-flight read tracker.
  always_comb begin
    rd_vld_d = i_issue;
    rd_col_d = i_issue ? i_col : rd_col_q;
  end

  // In-flight read tracker; reset drops any pending write.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rd_vld_q <= 1'b0;
      rd_col_q <= '0;
    end else begin
      rd_vld_q <= rd_vld_d;
      rd_col_q <= rd_col_d;
    end
  end

  // AND-OR select of the column word that arrives one cycle after its read.
  always_comb begin
    o_data = '0;
    for (int c = 0; c < COL; c++) begin
      o_data = o_data | ({DW{rd_col_q == COL_W'(c)}} & i_data[DW*c +: DW]);
    end
  end

  assign o_wren = rd_vld_q;

endmodule

// File: rtl/col_drain_scheduler.sv
// Drains ROWS words from each of COL column FIFOs, row-major, into one result FIFO.
module col_drain_scheduler
  import col_drain_pkg::*;
#(
  parameter int COL  = 3,
  parameter int ROWS = 3,
  parameter int DW   = 9
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [COL-1:0]    i_fifo_empty,
  input  logic [DW*COL-1:0] i_data,
  input  logic              i_out_afull,
  output logic [COL-1:0]    o_read_enable,
  output logic [DW-1:0]     o_data,
  output logic              o_wren,
  output logic              o_busy,
  output logic              o_done
);

  localparam int COL_W = max1_clog2(COL);
  localparam int ROW_W = max1_clog2(ROWS);

  state_e           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             src_empty_s;
  logic             issue_s;
  logic             last_col_s;
  logic             last_row_s;

  // Issue qualification for the current column; one afull slot covers the single in-flight write.
  always_comb begin
    src_empty_s = 1'b0;
    for (int c = 0; c < COL; c++) begin
      src_empty_s = src_empty_s | ((col_q == COL_W'(c)) & i_fifo_empty[c]);
    end
    issue_s    = (state_q == RUN) & ~src_empty_s & ~i_out_afull;
    last_col_s = (col_q == COL_W'(COL - 1));
    last_row_s = (row_q == ROW_W'(ROWS - 1));
  end

  // State and position counters.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Next state; stalls hold position so no column is ever skipped or re-read.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      IDLE: begin
        col_d = '0;
        row_d = '0;
        if (i_start) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (issue_s) begin
          if (last_col_s) begin
            col_d = '0;
            if (last_row_s) begin
              row_d   = '0;
              state_d = FLUSH;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        col_d   = '0;
        row_d   = '0;
      end
    endcase
  end

  // Output decode.
  always_comb begin
    o_read_enable = '0;
    for (int c = 0; c < COL; c++) begin
      o_read_enable[c] = issue_s & (col_q == COL_W'(c));
    end
    o_busy = (state_q != IDLE);
    o_done = (state_q == FLUSH);
  end

  drain_data_mux #(
    .COL (COL),
    .DW  (DW)
  ) u_data_mux (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_issue (issue_s),
    .i_col   (col_q),
    .i_data  (i_data),
    .o_data  (o_data),
    .o_wren  (o_wren)
  );

endmodule

// File: tb/tb_col_drain_scheduler.sv
// Directed bench for col_drain_scheduler with a simple registered-output column FIFO model.
module tb_col_drain_scheduler;

  localparam int COL  = 3;
  localparam int ROWS = 3;
  localparam int DW   = 9;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [COL-1:0]    empty;
  logic [DW*COL-1:0] data;
  logic              afull;
  logic [COL-1:0]    rd_en;
  logic [DW-1:0]     o_data;
  logic              wren;
  logic              busy;
  logic              done;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  logic           fifo_clr;
  int             ptr    [COL];
  logic [DW-1:0]  fifo_q [COL];

  logic [COL-1:0] rd_q[$];
  int             rd_cyc[$];
  logic [DW-1:0]  wr_q[$];
  int             wr_cyc[$];
  int             done_cyc[$];

  logic [COL-1:0] exp_rd  [9] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100,
                                  3'b001, 3'b010, 3'b100};
  logic [DW-1:0]  exp_dat [9] = '{9'h000, 9'h010, 9'h020, 9'h001, 9'h011, 9'h021,
                                  9'h002, 9'h012, 9'h022};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  col_drain_scheduler #(.COL(COL), .ROWS(ROWS), .DW(DW)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_fifo_empty  (empty),
    .i_data        (data),
    .i_out_afull   (afull),
    .o_read_enable (rd_en),
    .o_data        (o_data),
    .o_wren        (wren),
    .o_busy        (busy),
    .o_done        (done)
  );

  // Column c holds words 16*c + r; data appears the cycle after the read strobe.
  always @(posedge clk) begin
    for (int c = 0; c < COL; c++) begin
      if (fifo_clr) begin
        ptr[c]    <= 0;
        fifo_q[c] <= '0;
      end else if (rd_en[c]) begin
        fifo_q[c] <= DW'(16 * c + ptr[c]);
        ptr[c]    <= ptr[c] + 1;
      end
    end
  end

  for (genvar g = 0; g < COL; g++) begin : g_data
    assign data[DW*g +: DW] = fifo_q[g];
  end

  // Event log, sampled between clock edges.
  always @(negedge clk) begin
    #2;
    if (rd_en != '0) begin
      rd_q.push_back(rd_en);
      rd_cyc.push_back(cyc);
    end
    if (wren === 1'b1) begin
      wr_q.push_back(o_data);
      wr_cyc.push_back(cyc);
    end
    if (done === 1'b1) done_cyc.push_back(cyc);
  end

  task automatic clear_logs();
    rd_q.delete(); rd_cyc.delete(); wr_q.delete(); wr_cyc.delete(); done_cyc.delete();
  endtask

  task automatic fifo_reset();
    @(negedge clk); fifo_clr = 1'b1;
    @(negedge clk); fifo_clr = 1'b0;
    clear_logs();
  endtask

  task automatic start_batch(output int t);
    @(negedge clk); start = 1'b1; t = cyc;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; afull = 1'b0; empty = '0; fifo_clr = 1'b1;
    repeat (2) begin
      @(negedge clk); #3;
      checks++; if (rd_en !== 3'b000) $display("FAIL reset_rd_en: got %b want 000", rd_en); else passes++;
      checks++; if (wren !== 1'b0) $display("FAIL reset_wren: got %b want 0", wren); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
      checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passes++;
    end
    @(negedge clk); rst_n = 1'b1; fifo_clr = 1'b0;
    @(negedge clk); #3;
    checks++; if (rd_en !== 3'b000) $display("FAIL idle_rd_en: got %b want 000", rd_en); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else passes++;
  endtask

  task automatic test_full_drain();
    int t;
    logic [COL-1:0] g_rd;
    logic [DW-1:0]  g_wr;
    fifo_reset();
    start_batch(t);
    #3;
    checks++; if (busy !== 1'b1) $display("FAIL drain_busy_start: got %b want 1", busy); else passes++;
    repeat (14) @(negedge clk);
    #3;
    checks++; if (rd_q.size() != 9) $display("FAIL drain_rd_count: got %0d want 9", rd_q.size()); else passes++;
    checks++; if (wr_q.size() != 9) $display("FAIL drain_wr_count: got %0d want 9", wr_q.size()); else passes++;
    for (int i = 0; i < 9; i++) begin
      g_rd = (i < rd_q.size()) ? rd_q[i] : 'x;
      g_wr = (i < wr_q.size()) ? wr_q[i] : 'x;
      checks++; if (g_rd !== exp_rd[i]) $display("FAIL drain_rd[%0d]: got %b want %b", i, g_rd, exp_rd[i]); else passes++;
      checks++; if (g_wr !== exp_dat[i]) $display("FAIL drain_data[%0d]: got %h want %h", i, g_wr, exp_dat[i]); else passes++;
      checks++; if (i < rd_cyc.size() && rd_cyc[i] != t + 1 + i) $display("FAIL drain_rd_cycle[%0d]: got %0d want %0d", i, rd_cyc[i] - t, 1 + i); else passes++;
    end
    checks++; if (done_cyc.size() != 1) $display("FAIL drain_done_count: got %0d want 1", done_cyc.size()); else passes++;
    checks++; if (done_cyc.size() < 1 || done_cyc[0] != t + 10) $display("FAIL drain_done_latency: got %0d want 10", (done_cyc.size() > 0) ? done_cyc[0] - t : -1); else passes++;
    checks++; if (wr_cyc.size() < 9 || wr_cyc[8] != t + 10) $display("FAIL drain_last_wren: got %0d want 10", (wr_cyc.size() > 8) ? wr_cyc[8] - t : -1); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL drain_busy_end: got %b want 0", busy); else passes++;
  endtask

  task automatic test_source_stall();
    int t;
    int n;
    logic [COL-1:0] g_rd;
    logic [DW-1:0]  g_wr;
    fifo_reset();
    start_batch(t);
    @(negedge clk); empty = 3'b010;
    repeat (5) @(negedge clk);
    empty = 3'b000;
    repeat (12) @(negedge clk);
    #3;
    n = 0;
    foreach (rd_cyc[k]) if (rd_cyc[k] >= t + 2 && rd_cyc[k] <= t + 6) n++;
    checks++; if (n != 0) $display("FAIL stall_reads_during: got %0d want 0", n); else passes++;
    checks++; if (wr_q.size() != 9) $display("FAIL stall_wr_count: got %0d want 9", wr_q.size()); else passes++;
    for (int i = 0; i < 9; i++) begin
      g_rd = (i < rd_q.size()) ? rd_q[i] : 'x;
      g_wr = (i < wr_q.size()) ? wr_q[i] : 'x;
      checks++; if (g_rd !== exp_rd[i]) $display("FAIL stall_rd[%0d]: got %b want %b", i, g_rd, exp_rd[i]); else passes++;
      checks++; if (g_wr !== exp_dat[i]) $display("FAIL stall_data[%0d]: got %h want %h", i, g_wr, exp_dat[i]); else passes++;
    end
    checks++; if (rd_cyc.size() < 2 || rd_cyc[1] != t + 7) $display("FAIL stall_resume: got %0d want 7", (rd_cyc.size() > 1) ? rd_cyc[1] - t : -1); else passes++;
    checks++; if (done_cyc.size() != 1 || done_cyc[0] != t + 15) $display("FAIL stall_done: got %0d want 15", (done_cyc.size() > 0) ? done_cyc[0] - t : -1); else passes++;
  endtask

  task automatic test_backpressure();
    int t;
    int nr;
    int nw;
    logic [DW-1:0] g_wr;
    fifo_reset();
    start_batch(t);
    repeat (3) @(negedge clk);
    afull = 1'b1;
    repeat (4) @(negedge clk);
    afull = 1'b0;
    repeat (10) @(negedge clk);
    #3;
    nr = 0; nw = 0;
    foreach (rd_cyc[k]) if (rd_cyc[k] >= t + 4 && rd_cyc[k] <= t + 7) nr++;
    foreach (wr_cyc[k]) if (wr_cyc[k] >= t + 4 && wr_cyc[k] <= t + 7) nw++;
    checks++; if (nr != 0) $display("FAIL afull_reads_during: got %0d want 0", nr); else passes++;
    checks++; if (nw != 1) $display("FAIL afull_trailing_wren: got %0d want 1", nw); else passes++;
    checks++; if (rd_q.size() != 9) $display("FAIL afull_rd_count: got %0d want 9", rd_q.size()); else passes++;
    for (int i = 0; i < 9; i++) begin
      g_wr = (i < wr_q.size()) ? wr_q[i] : 'x;
      checks++; if (g_wr !== exp_dat[i]) $display("FAIL afull_data[%0d]: got %h want %h", i, g_wr, exp_dat[i]); else passes++;
    end
    checks++; if (done_cyc.size() != 1 || done_cyc[0] != t + 14) $display("FAIL afull_done: got %0d want 14", (done_cyc.size() > 0) ? done_cyc[0] - t : -1); else passes++;
  endtask

  task automatic test_start_while_busy();
    int t;
    fifo_reset();
    start_batch(t);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    #3;
    checks++; if (rd_q.size() != 9) $display("FAIL busy_start_reads: got %0d want 9", rd_q.size()); else passes++;
    checks++; if (wr_q.size() != 9) $display("FAIL busy_start_writes: got %0d want 9", wr_q.size()); else passes++;
    checks++; if (done_cyc.size() != 1) $display("FAIL busy_start_dones: got %0d want 1", done_cyc.size()); else passes++;
    checks++; if (done_cyc.size() < 1 || done_cyc[0] != t + 10) $display("FAIL busy_start_done_cycle: got %0d want 10", (done_cyc.size() > 0) ? done_cyc[0] - t : -1); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL busy_start_idle: got %b want 0", busy); else passes++;
  endtask

  task automatic test_reset_mid_batch();
    int t;
    fifo_reset();
    start_batch(t);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #3;
    checks++; if (rd_en !== 3'b001) $display("FAIL midrst_4th_read: got %b want 001", rd_en); else passes++;
    @(negedge clk); rst_n = 1'b1;
    #3;
    checks++; if (wren !== 1'b0) $display("FAIL midrst_wren: got %b want 0", wren); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL midrst_done: got %b want 0", done); else passes++;
    repeat (3) @(negedge clk);
    #3;
    checks++; if (wr_q.size() != 3) $display("FAIL midrst_writes: got %0d want 3", wr_q.size()); else passes++;
    checks++; if (done_cyc.size() != 0) $display("FAIL midrst_no_done: got %0d want 0", done_cyc.size()); else passes++;
    fifo_reset();
    start_batch(t);
    repeat (14) @(negedge clk);
    #3;
    checks++; if (rd_q.size() < 1 || rd_q[0] !== 3'b001) $display("FAIL restart_first_rd: got %b want 001", (rd_q.size() > 0) ? rd_q[0] : 3'bxxx); else passes++;
    checks++; if (wr_q.size() < 1 || wr_q[0] !== 9'h000) $display("FAIL restart_first_data: got %h want 000", (wr_q.size() > 0) ? wr_q[0] : 9'hxxx); else passes++;
    checks++; if (wr_q.size() != 9) $display("FAIL restart_writes: got %0d want 9", wr_q.size()); else passes++;
    checks++; if (done_cyc.size() != 1 || done_cyc[0] != t + 10) $display("FAIL restart_done: got %0d want 10", (done_cyc.size() > 0) ? done_cyc[0] - t : -1); else passes++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_full_drain();
    test_source_stall();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_batch();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
